// File: rtl/ram_banked.sv
// ram_banked: byte-lane data memory for the RV32I core with a memory-mapped UART TX path.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   clk_en              core-side enable for reads, writes and TX pushes
//   i_read_req/addr     data read request and word address
//   o_read_data/valid   registered data read result and its valid flag (1-cycle latency)
//   i_read_fetch_addr   fetch word address, read every enabled cycle
//   o_read_fetch_data   registered fetch result
//   i_write_*           byte-enabled write port (RAM, UART data register, status register)
//   o_uart_data/valid   head-of-queue byte and non-empty flag
//   i_uart_ready        transmitter accepts the head byte (pop, independent of clk_en)
//
// Address map (word addresses): 0..ADDR_COUNT-1 RAM, UART_ADDR TX data (write-only, reads 0),
// STATUS_ADDR status {overflow, full, empty, count[7:0]}; everything else reads 0, writes ignored.
//
// Build option: define RAM_UART_FIFO_EN for a FIFO_DEPTH-entry TX FIFO; otherwise the TX path
// is a single-entry holding register (full when count==1).

module ram_banked #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned LANES       = DATA_WIDTH / 8,
  parameter int unsigned ADDR_COUNT  = 1024,
  parameter int unsigned UART_ADDR   = ADDR_COUNT,
  parameter int unsigned STATUS_ADDR = ADDR_COUNT + 1,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clk_en,
  input  logic                  i_read_req,
  input  logic [ADDR_WIDTH-1:0] i_read_addr,
  output logic [DATA_WIDTH-1:0] o_read_data,
  output logic                  o_read_valid,
  input  logic [ADDR_WIDTH-1:0] i_read_fetch_addr,
  output logic [DATA_WIDTH-1:0] o_read_fetch_data,
  input  logic                  i_write_enable,
  input  logic [LANES-1:0]      i_byte_enable,
  input  logic [ADDR_WIDTH-1:0] i_write_addr,
  input  logic [DATA_WIDTH-1:0] i_write_data,
  output logic [7:0]            o_uart_data,
  output logic                  o_uart_valid,
  input  logic                  i_uart_ready
);

  localparam int unsigned RamAw = (ADDR_COUNT > 1) ? $clog2(ADDR_COUNT) : 1;
  // Count must reach FIFO_DEPTH itself, hence the +1.
  localparam int unsigned CntW  = $clog2(FIFO_DEPTH + 1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic             wr_in_ram;
  logic             wr_is_uart;
  logic             wr_is_status;
  logic             ram_we;
  logic [RamAw-1:0] rd_idx;
  logic [RamAw-1:0] fetch_idx;
  logic [RamAw-1:0] wr_idx;

  assign wr_in_ram    = i_write_addr < ADDR_WIDTH'(ADDR_COUNT);
  assign wr_is_uart   = i_write_addr == ADDR_WIDTH'(UART_ADDR);
  assign wr_is_status = i_write_addr == ADDR_WIDTH'(STATUS_ADDR);
  assign ram_we       = clk_en & i_write_enable & wr_in_ram;

  // Out-of-range addresses may alias here; the range checks keep them from taking effect.
  assign rd_idx    = i_read_addr[RamAw-1:0];
  assign fetch_idx = i_read_fetch_addr[RamAw-1:0];
  assign wr_idx    = i_write_addr[RamAw-1:0];

  // ---------------------------------------------------------------------------
  // Lane storage: one byte-wide array per lane, combinational read, registered below
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_ram_word;
  logic [DATA_WIDTH-1:0] fetch_ram_word;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [7:0] mem_q [ADDR_COUNT];

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
      if (ram_we && i_byte_enable[k]) begin
        mem_q[wr_idx] <= i_write_data[8*k +: 8];
      end
    end

    assign rd_ram_word[8*k +: 8]    = mem_q[rd_idx];
    assign fetch_ram_word[8*k +: 8] = mem_q[fetch_idx];
  end

  // ---------------------------------------------------------------------------
  // TX queue control (shared by both build options)
  // ---------------------------------------------------------------------------
  logic [CntW-1:0] count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            tx_empty;
  logic            tx_full;
  logic [7:0]      tx_head;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            ovf_set;
  logic            ovf_clr;

  assign tx_empty = (count_q == '0);
  assign push_req = clk_en & i_write_enable & wr_is_uart & i_byte_enable[0];
  assign pop      = ~tx_empty & i_uart_ready;
  // A simultaneous pop frees a slot, so a push into a full queue still lands.
  assign push_ok  = push_req & (~tx_full | pop);
  assign ovf_set  = push_req & tx_full & ~pop;
  assign ovf_clr  = clk_en & i_write_enable & wr_is_status & i_byte_enable[0];

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Clear first so a same-cycle overflow wins.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (ovf_set) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

`ifdef RAM_UART_FIFO_EN
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [7:0]      fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;

  // Power-of-two depth: pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) begin
        fifo_q[wr_ptr_q] <= i_write_data[7:0];
        wr_ptr_q         <= wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
    end
  end

  assign tx_full = (count_q == CntW'(FIFO_DEPTH));
  assign tx_head = fifo_q[rd_ptr_q];
`else
  logic [7:0] hold_q;

  // With one entry, push-while-full is only accepted alongside a pop, so overwriting is safe.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      hold_q <= i_write_data[7:0];
    end
  end

  assign tx_full = (count_q == CntW'(1));
  assign tx_head = hold_q;
`endif

  assign o_uart_valid = ~tx_empty;
  // Storage is not reset, so mask the head byte while empty.
  assign o_uart_data  = tx_empty ? 8'h00 : tx_head;

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] status_word;

  always_comb begin
    status_word       = '0;
    status_word[7:0]  = 8'(count_q);
    status_word[8]    = tx_empty;
    status_word[9]    = tx_full;
    status_word[10]   = ovf_q;
  end

  function automatic logic [DATA_WIDTH-1:0] read_mux(input logic [ADDR_WIDTH-1:0] addr,
                                                     input logic [DATA_WIDTH-1:0] ram_word,
                                                     input logic [DATA_WIDTH-1:0] status);
    if (addr < ADDR_WIDTH'(ADDR_COUNT)) begin
      return ram_word;
    end else if (addr == ADDR_WIDTH'(STATUS_ADDR)) begin
      return status;
    end
    return '0;
  endfunction

  logic [DATA_WIDTH-1:0] read_data_q;
  logic [DATA_WIDTH-1:0] fetch_data_q;
  logic                  read_valid_q;

  // Status is sampled from pre-update state, so a same-cycle push is not yet counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      read_data_q  <= '0;
      fetch_data_q <= '0;
      read_valid_q <= 1'b0;
    end else if (clk_en) begin
      read_data_q  <= read_mux(i_read_addr, rd_ram_word, status_word);
      fetch_data_q <= read_mux(i_read_fetch_addr, fetch_ram_word, status_word);
      read_valid_q <= i_read_req;
    end
  end

  assign o_read_data       = read_data_q;
  assign o_read_fetch_data = fetch_data_q;
  assign o_read_valid      = read_valid_q;

endmodule

// File: tb/tb_ram_banked.sv
// tb_ram_banked: directed scenarios plus randomized traffic against a queue/array model.

module tb_ram_banked;

  localparam int unsigned AC = 1024;
  localparam int unsigned UA = AC;
  localparam int unsigned SA = AC + 1;
  localparam int unsigned FD = 8;
`ifdef RAM_UART_FIFO_EN
  localparam int unsigned TxDepth = FD;
`else
  localparam int unsigned TxDepth = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic        read_req;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        read_valid;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_data;
  logic        we;
  logic [3:0]  be;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ready;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit [31:0]    mem_m [AC];
  byte unsigned q_m[$];
  bit           ovf_m;
  bit [31:0]    exp_rd;
  bit [31:0]    exp_fetch;
  bit           exp_valid;

  ram_banked #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .LANES      (4),
    .ADDR_COUNT (AC),
    .UART_ADDR  (UA),
    .STATUS_ADDR(SA),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .clk_en           (clk_en),
    .i_read_req       (read_req),
    .i_read_addr      (read_addr),
    .o_read_data      (read_data),
    .o_read_valid     (read_valid),
    .i_read_fetch_addr(fetch_addr),
    .o_read_fetch_data(fetch_data),
    .i_write_enable   (we),
    .i_byte_enable    (be),
    .i_write_addr     (waddr),
    .i_write_data     (wdata),
    .o_uart_data      (uart_data),
    .o_uart_valid     (uart_valid),
    .i_uart_ready     (uart_ready)
  );

  always #5 clk = ~clk;

  function automatic bit [31:0] model_read(input bit [31:0] a);
    bit [31:0] w;
    w = '0;
    if (a < AC) begin
      w = mem_m[a];
    end else if (a == SA) begin
      w[7:0] = 8'(q_m.size());
      w[8]   = (q_m.size() == 0);
      w[9]   = (q_m.size() == TxDepth);
      w[10]  = ovf_m;
    end
    return w;
  endfunction

  // Apply the current inputs to the model, then advance one clock; returns 1 ns after the edge.
  task automatic tick();
    bit pop;
    bit push;
    bit full;
    if (rst) begin
      exp_rd    = '0;
      exp_fetch = '0;
      exp_valid = 1'b0;
      q_m.delete();
      ovf_m     = 1'b0;
    end else begin
      full = (q_m.size() == TxDepth);
      pop  = (q_m.size() != 0) && uart_ready;
      push = clk_en && we && (waddr == UA) && be[0];
      if (clk_en) begin
        exp_rd    = model_read(read_addr);
        exp_fetch = model_read(fetch_addr);
        exp_valid = read_req;
      end
      if (clk_en && we && waddr < AC) begin
        for (int k = 0; k < 4; k++) begin
          if (be[k]) mem_m[waddr][8*k +: 8] = wdata[8*k +: 8];
        end
      end
      if (clk_en && we && waddr == SA && be[0]) ovf_m = 1'b0;
      if (pop) void'(q_m.pop_front());
      if (push) begin
        if (full && !pop) ovf_m = 1'b1;
        else q_m.push_back(wdata[7:0]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    clk_en     = 1'b1;
    read_req   = 1'b0;
    we         = 1'b0;
    be         = 4'h0;
    uart_ready = 1'b0;
  endtask

  task automatic do_write(input bit [31:0] a, input bit [31:0] d, input bit [3:0] b);
    we    = 1'b1;
    waddr = a;
    wdata = d;
    be    = b;
    tick();
    we    = 1'b0;
    be    = 4'h0;
  endtask

  task automatic do_read(input bit [31:0] a);
    read_req  = 1'b1;
    read_addr = a;
    tick();
    read_req  = 1'b0;
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    idle();
    read_addr  = '0;
    fetch_addr = UA;
    waddr      = '0;
    wdata      = '0;
    tick();
    tick();
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL reset_read_data: got %h want 00000000", read_data); end
    checks++; if (read_valid !== 1'b0) begin errors++;
      $display("FAIL reset_read_valid: got %b want 0", read_valid); end
    checks++; if (fetch_data !== 32'h0) begin errors++;
      $display("FAIL reset_fetch_data: got %h want 00000000", fetch_data); end
    checks++; if (uart_valid !== 1'b0) begin errors++;
      $display("FAIL reset_uart_valid: got %b want 0", uart_valid); end
    checks++; if (uart_data !== 8'h00) begin errors++;
      $display("FAIL reset_uart_data: got %h want 00", uart_data); end
    rst = 1'b0;
    do_read(SA);
    checks++; if (read_data !== 32'h100) begin errors++;
      $display("FAIL reset_status: got %h want 00000100", read_data); end
  endtask

  // Give every word the bench touches a known value.
  task automatic init_mem();
    for (int a = 0; a < 16; a++) do_write(a, 32'h0, 4'hF);
    do_write(AC - 1, 32'h0, 4'hF);
  endtask

  task automatic test_lane_write();
    do_write(5, 32'hAABBCCDD, 4'hF);
    do_write(5, 32'h00000011, 4'h1);
    do_read(5);
    checks++; if (read_data !== 32'hAABBCC11) begin errors++;
      $display("FAIL lane_write_data: got %h want aabbcc11", read_data); end
    checks++; if (read_valid !== 1'b1) begin errors++;
      $display("FAIL lane_write_valid: got %b want 1", read_valid); end
    tick();
    checks++; if (read_valid !== 1'b0) begin errors++;
      $display("FAIL lane_valid_drop: got %b want 0", read_valid); end
  endtask

  task automatic test_read_first();
    we        = 1'b1;
    waddr     = 3;
    wdata     = 32'h12345678;
    be        = 4'hF;
    read_req  = 1'b1;
    read_addr = 3;
    tick();
    idle();
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL read_first_old: got %h want 00000000", read_data); end
    do_read(3);
    checks++; if (read_data !== 32'h12345678) begin errors++;
      $display("FAIL read_first_new: got %h want 12345678", read_data); end
  endtask

  task automatic test_fifo_overflow();
    bit [31:0] want;
    for (int i = 0; i <= TxDepth; i++) do_write(UA, 32'h41 + i, 4'h1);
    do_read(SA);
    want = (32'h1 << 10) | (32'h1 << 9) | TxDepth;
    checks++; if (read_data !== want) begin errors++;
      $display("FAIL overflow_status: got %h want %h", read_data, want); end
    uart_ready = 1'b1;
    for (int i = 0; i < TxDepth; i++) begin
      checks++; if (uart_valid !== 1'b1 || uart_data !== 8'(8'h41 + i)) begin errors++;
        $display("FAIL overflow_drain[%0d]: got v=%b %h want v=1 %h", i, uart_valid, uart_data,
                 8'(8'h41 + i)); end
      tick();
    end
    uart_ready = 1'b0;
    checks++; if (uart_valid !== 1'b0) begin errors++;
      $display("FAIL overflow_dropped: got valid %b want 0", uart_valid); end
    do_write(SA, 32'h0, 4'h1);
    do_read(SA);
    checks++; if (read_data !== 32'h100) begin errors++;
      $display("FAIL overflow_clear: got %h want 00000100", read_data); end
  endtask

  task automatic test_push_pop_full();
    bit [31:0] want;
    bit [7:0]  wb;
    for (int i = 0; i < TxDepth; i++) do_write(UA, 32'h30 + i, 4'h1);
    checks++; if (uart_data !== 8'h30) begin errors++;
      $display("FAIL full_head: got %h want 30", uart_data); end
    uart_ready = 1'b1;
    do_write(UA, 32'h5A, 4'h1);
    uart_ready = 1'b0;
    do_read(SA);
    want = (32'h1 << 9) | TxDepth;
    checks++; if (read_data !== want) begin errors++;
      $display("FAIL push_pop_status: got %h want %h", read_data, want); end
    uart_ready = 1'b1;
    for (int i = 0; i < TxDepth; i++) begin
      wb = (i == TxDepth - 1) ? 8'h5A : 8'(8'h31 + i);
      checks++; if (uart_valid !== 1'b1 || uart_data !== wb) begin errors++;
        $display("FAIL push_pop_drain[%0d]: got v=%b %h want v=1 %h", i, uart_valid, uart_data,
                 wb); end
      tick();
    end
    uart_ready = 1'b0;
    checks++; if (uart_valid !== 1'b0) begin errors++;
      $display("FAIL push_pop_empty: got valid %b want 0", uart_valid); end
  endtask

  task automatic test_reset_mid_drain();
    int n;
    n = (TxDepth < 4) ? TxDepth : 4;
    for (int i = 0; i < n; i++) do_write(UA, 32'h60 + i, 4'h1);
    rst        = 1'b1;
    uart_ready = 1'b1;
    do_write(UA, 32'h77, 4'h1);
    rst        = 1'b0;
    uart_ready = 1'b0;
    checks++; if (uart_valid !== 1'b0 || uart_data !== 8'h00) begin errors++;
      $display("FAIL rst_drain_uart: got v=%b %h want v=0 00", uart_valid, uart_data); end
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL rst_drain_rdata: got %h want 00000000", read_data); end
    tick();
    checks++; if (uart_valid !== 1'b0) begin errors++;
      $display("FAIL rst_drain_push: got valid %b want 0", uart_valid); end
    do_read(SA);
    checks++; if (read_data !== 32'h100) begin errors++;
      $display("FAIL rst_drain_status: got %h want 00000100", read_data); end
    do_read(5);
    checks++; if (read_data !== 32'hAABBCC11) begin errors++;
      $display("FAIL rst_drain_ram: got %h want aabbcc11", read_data); end
  endtask

  task automatic test_clk_en();
    fetch_addr = 5;
    do_read(5);
    clk_en     = 1'b0;
    read_addr  = 3;
    fetch_addr = 3;
    do_write(7, 32'hDEADBEEF, 4'hF);
    do_write(UA, 32'h99, 4'h1);
    checks++; if (read_data !== 32'hAABBCC11 || read_valid !== 1'b1) begin errors++;
      $display("FAIL clk_en_hold_read: got v=%b %h want v=1 aabbcc11", read_valid, read_data); end
    checks++; if (fetch_data !== 32'hAABBCC11) begin errors++;
      $display("FAIL clk_en_hold_fetch: got %h want aabbcc11", fetch_data); end
    checks++; if (uart_valid !== 1'b0) begin errors++;
      $display("FAIL clk_en_no_push: got valid %b want 0", uart_valid); end
    clk_en     = 1'b1;
    fetch_addr = UA;
    do_read(7);
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL clk_en_no_write: got %h want 00000000", read_data); end
    do_read(SA);
    checks++; if (read_data !== 32'h100) begin errors++;
      $display("FAIL clk_en_status: got %h want 00000100", read_data); end
  endtask

  task automatic test_unmapped();
    do_write(AC + 2, 32'hFFFFFFFF, 4'hF);
    fetch_addr = AC + 2;
    do_read(AC + 2);
    checks++; if (read_data !== 32'h0 || read_valid !== 1'b1) begin errors++;
      $display("FAIL unmapped_read: got v=%b %h want v=1 00000000", read_valid, read_data); end
    checks++; if (fetch_data !== 32'h0) begin errors++;
      $display("FAIL unmapped_fetch: got %h want 00000000", fetch_data); end
    fetch_addr = UA;
    do_read(2);
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL unmapped_alias: got %h want 00000000", read_data); end
    do_read(UA);
    checks++; if (read_data !== 32'h0) begin errors++;
      $display("FAIL uart_addr_read: got %h want 00000000", read_data); end
  endtask

  function automatic bit [31:0] pick_addr();
    int unsigned r;
    r = $urandom_range(0, 19);
    if (r < 16) return r;
    if (r == 16) return UA;
    if (r == 17) return SA;
    if (r == 18) return AC + 2;
    return AC - 1;
  endfunction

  task automatic test_random();
    bit [7:0] wb;
    for (int n = 0; n < 400; n++) begin
      clk_en     = ($urandom_range(0, 3) != 0);
      read_req   = $urandom_range(0, 1);
      read_addr  = pick_addr();
      fetch_addr = pick_addr();
      we         = ($urandom_range(0, 2) != 0);
      waddr      = ($urandom_range(0, 2) == 0) ? UA : pick_addr();
      wdata      = $urandom;
      be         = 4'($urandom_range(0, 15));
      uart_ready = ($urandom_range(0, 2) == 0);
      tick();
      wb = (q_m.size() != 0) ? q_m[0] : 8'h00;
      checks++; if (read_data !== exp_rd) begin errors++;
        $display("FAIL rand_read_data[%0d]: got %h want %h", n, read_data, exp_rd); end
      checks++; if (read_valid !== exp_valid) begin errors++;
        $display("FAIL rand_read_valid[%0d]: got %b want %b", n, read_valid, exp_valid); end
      checks++; if (fetch_data !== exp_fetch) begin errors++;
        $display("FAIL rand_fetch[%0d]: got %h want %h", n, fetch_data, exp_fetch); end
      checks++; if (uart_valid !== (q_m.size() != 0)) begin errors++;
        $display("FAIL rand_uart_valid[%0d]: got %b want %b", n, uart_valid, q_m.size() != 0); end
      checks++; if (uart_data !== wb) begin errors++;
        $display("FAIL rand_uart_data[%0d]: got %h want %h", n, uart_data, wb); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    init_mem();
    test_lane_write();
    test_read_first();
    test_fifo_overflow();
    test_push_pop_full();
    test_reset_mid_drain();
    test_clk_en();
    test_unmapped();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ram_banked.md
# ram_banked

Parametrised byte-lane data memory for the RV32I core, replacing the fixed four-lane RAM. It provides:
- one data read port and one instruction-fetch read port, both with a one-cycle registered latency;
- one byte-enabled write port;
- a memory-mapped UART transmit path, buffered in a FIFO with a ready/valid drain handshake and a readable status word.

It sits between the core's load/store and fetch stages and the UART transmitter.

## Interface
Parameters:
- ADDR_WIDTH, 32, full width of all word-address inputs (no minus-one convention).
- DATA_WIDTH, 32, word width; must be a multiple of 8.
- LANES, DATA_WIDTH/8, byte lanes; one storage array per lane.
- ADDR_COUNT, 1024, number of RAM words, at word addresses 0..ADDR_COUNT-1.
- UART_ADDR, ADDR_COUNT, word address of the UART TX data register.
- STATUS_ADDR, ADDR_COUNT+1, word address of the UART status register.
- FIFO_DEPTH, 8, TX FIFO entries; must be a power of two, 2..128.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- clk_en  in  1  core-side enable; gates reads, writes and FIFO pushes.
- i_read_req  in  1  data read request.
- i_read_addr  in  ADDR_WIDTH  data read word address.
- o_read_data  out  DATA_WIDTH  data read result.
- o_read_valid  out  1  o_read_data is valid this cycle.
- i_read_fetch_addr  in  ADDR_WIDTH  fetch word address; read every enabled cycle.
- o_read_fetch_data  out  DATA_WIDTH  fetch result.
- i_write_enable  in  1  write strobe.
- i_byte_enable  in  LANES  per-lane write enables.
- i_write_addr  in  ADDR_WIDTH  write word address.
- i_write_data  in  DATA_WIDTH  write data.
- o_uart_data  out  8  head-of-FIFO byte.
- o_uart_valid  out  1  FIFO non-empty.
- i_uart_ready  in  1  transmitter accepts the byte.

## Operation
RAM:
- A write with clk_en=1 and i_write_enable=1 to an address below ADDR_COUNT updates lane k iff i_byte_enable[k]=1.
- Writes to any other unmapped address are ignored.
- Reads are read-first: a read of the address being written in the same cycle returns the old data.
- Memory contents are not reset.

Data read port:
- When clk_en=1, o_read_data is registered from i_read_addr and o_read_valid <= i_read_req.
- Reads of UART_ADDR and of unmapped addresses return 0.
- A read of STATUS_ADDR returns a zero-extended word:
  - [7:0] count
  - [8] empty
  - [9] full
  - [10] overflow (sticky)

Fetch read port:
- Same as the data port but with no valid flag; unmapped addresses return 0.

TX FIFO:
- Push: clk_en=1, i_write_enable=1, i_write_addr=UART_ADDR and i_byte_enable[0]=1; the pushed value is i_write_data[7:0].
- Pop: o_uart_valid=1 and i_uart_ready=1. Pops are independent of clk_en.
- Push while full, with no pop in the same cycle: the byte is dropped and overflow <= 1.
- Push and pop in the same cycle: both are performed and count is unchanged. This also applies when full, so no byte is dropped.
- A write to STATUS_ADDR with i_byte_enable[0]=1 clears overflow. If an overflowing push happens in the same cycle, the set wins.
- Read and write pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.

## Timing
- Read latency on both read ports is 1 cycle.
- When clk_en=0: o_read_data and o_read_fetch_data hold, and o_read_valid holds.
- A pushed byte appears on o_uart_data/o_uart_valid on the next cycle.
- A status read issued in the same cycle as a push reports the pre-push count.
- Reset values:
  - o_read_data = 0
  - o_read_fetch_data = 0
  - o_read_valid = 0
  - o_uart_valid = 0
  - o_uart_data = 0
  - count = 0
  - overflow = 0
- Reset asserted mid-drain empties the FIFO on the next edge. A byte presented in that cycle is discarded, and so is any push in the same cycle.

## Configuration
RAM_UART_FIFO_EN:
- Defined: TX path is the FIFO_DEPTH-entry FIFO described above.
- Undefined: TX path is a single-entry holding register.
  - FIFO_DEPTH is ignored and full = (count==1).
  - Overflow and status-register behaviour are otherwise identical.

## Test plan
- Lane writes, DATA_WIDTH=32:
  - stimulus: write 0xAABBCCDD to addr 5 with be=1111, then 0x11 with be=0001; read addr 5;
  - response: o_read_data=0xAABBCC11 one cycle after the request, o_read_valid=1.
- Read-first collision:
  - stimulus: addr 3 holds 0x0; in one cycle, write 0x12345678 and read addr 3;
  - response: read returns 0x0; the read on the next cycle returns 0x12345678.
- FIFO fill and overflow:
  - stimulus: FIFO_DEPTH=8, i_uart_ready=0; push 9 bytes 0x41..0x49;
  - response: status = count 8, full 1, overflow 1 (0x608); then assert ready and drain: bytes 0x41..0x48 come out in order and 0x49 is never emitted.
- Push and pop while full:
  - stimulus: FIFO full; push 0x5A in the same cycle as a pop;
  - response: count stays 8, overflow stays 0, and 0x5A is the last byte drained.
- Reset mid-drain:
  - stimulus: 4 bytes queued; pulse rst for one cycle with ready=1;
  - response: after reset, o_uart_valid=0, the status read returns 0x100, and the RAM word at addr 5 is preserved.
- clk_en and unmapped addresses:
  - stimulus 1: clk_en=0 with a write to addr 7 and a UART push;
  - response 1: no memory change, no FIFO entry, outputs hold;
  - stimulus 2: read of address ADDR_COUNT+2;
  - response 2: returns 0.
